pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline-register banks and the PC register. It also tracks multi-cycle memory waits and keeps saturating stall/flush statistics. It sits directly upstream of every pipeline register: its `*_en` outputs connect to register `en` pins, and its `*_flush` outputs are ORed into register `rst` pins.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall-cycle counter.
- `FL_W`, default 16: width of the branch-flush counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-low.
- `id_rs1`, `id_rs2` in 5 each: source register numbers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction actually reads that source.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_branch_taken` in 1: EX resolved a taken branch or jump.
- `dmem_busy` in 1: data memory is not ready this cycle.
- `imem_busy` in 1: instruction memory is not ready this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: register-bank enables.
- `ifid_flush`, `idex_flush` out 1 each: force the bank to zero (bubble) on the next edge.
- `stall_cnt` out CNT_W: count of cycles with `pc_en`=0; saturates.
- `flush_cnt` out FL_W: count of branch flushes; saturates.

## Operation
- **Load-use hit:** `ex_mem_read` AND `ex_rd`≠0 AND ((`id_use_rs1` AND `id_rs1`==`ex_rd`) OR (`id_use_rs2` AND `id_rs2`==`ex_rd`)).
- **FSM states:** RUN, LDSTALL, MEMWAIT.
- **Priority per cycle (highest first):**
  1. `dmem_busy`: all five enables 0; both flushes 0. Next state MEMWAIT.
  2. `ex_branch_taken`: all enables 1; `ifid_flush`=`idex_flush`=1; `flush_cnt` increments. Next state RUN.
  3. Load-use hit while in RUN or MEMWAIT: `pc_en`=`ifid_en`=0, `idex_flush`=1, other enables 1. Next state LDSTALL.
  4. `imem_busy`: `pc_en`=0, `ifid_flush`=1, other enables 1. Next state RUN.
  5. Otherwise: all enables 1, flushes 0. Next state RUN.
- **In LDSTALL:** load-use detection is masked for that one cycle (EX holds the bubble). Rules 1, 2 and 4 still apply. The state always leaves LDSTALL after one cycle.
- **MEMWAIT:** exits to RUN or LDSTALL on the first cycle `dmem_busy`=0. A branch held in the frozen EX stage is taken on that exit cycle.
- **Counters:** `stall_cnt` increments on every non-reset cycle with `pc_en`=0. Both counters hold at all-ones (no wrap).
- **Reset (rst=0 at an edge):**
  - state becomes RUN and both counters become 0;
  - while `rst`=0, all enables are 0 and both flushes are 0, regardless of other inputs;
  - reset mid-stall or mid-MEMWAIT aborts it with no residual stall.

## Timing
- Enables and flushes are combinational from the current inputs and the registered state. There is zero-cycle latency: they act on the same edge as the hazard condition.
- State and counters are registered. Counter outputs reflect events up to the previous edge.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 squashed slots. A `dmem_busy` of N cycles freezes the pipeline for exactly N cycles.
- Simultaneous events:
  - branch and load-use together: the branch wins, with no stall;
  - `dmem_busy` and branch together: freeze; the branch is taken when busy drops;
  - `imem_busy` and load-use together: load-use wins (`ifid_en`=0, no `ifid_flush`).

## Structure
- Shared package `pipe_ctrl_pkg`:
  - FSM state enum (RUN, LDSTALL, MEMWAIT);
  - constant `REG_ZERO`=5'd0;
  - register-index width 5.
- One natural combinational sub-module: `load_use_cmp`, with inputs `id_rs1/rs2`, `id_use_*`, `ex_rd`, `ex_mem_read` and output `hit`.
- The top module holds the FSM, priority mux, saturating counters and reset gating.

## Test plan
- `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 → that cycle `pc_en`=0, `ifid_en`=0, `idex_flush`=1. Next cycle in LDSTALL with the same ID operands → all enables 1. `stall_cnt`=1.
- `ex_rd`=0 with `id_rs1`=0 and a load in EX → no stall; all enables 1.
- `ex_branch_taken`=1 together with a load-use hit → `ifid_flush`=`idex_flush`=1, `pc_en`=1, `flush_cnt` goes 0→1, no stall.
- `dmem_busy`=1 for 3 cycles with `ex_branch_taken`=1 held → all enables 0 for 3 cycles, `stall_cnt`=3. On cycle 4, the flushes assert once.
- `rst`=0 asserted during MEMWAIT → all outputs 0 that cycle and counters 0 after the edge. After release with quiet inputs → all enables 1, state RUN.
- Force `stall_cnt` near saturation (CNT_W=4 build) and hold `imem_busy`=1 for 20 cycles → `stall_cnt` stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDSTALL,
        ST_MEMWAIT
    } hz_state_e;

endpackage

// File: rtl/load_use_cmp.sv
// Detects a load in EX whose destination feeds a live source operand of the ID instruction.
module load_use_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             hit
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
    assign hit       = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: drives pipeline-bank enables and bubbles, tracks memory
// waits and keeps saturating stall and branch-flush statistics.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned FL_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    input  logic             imem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [FL_W-1:0]  flush_cnt
);

    hz_state_e state;
    hz_state_e state_nx;
    logic      lu_hit;
    logic      branch_go;

    load_use_cmp u_load_use_cmp (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hit         (lu_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Priority: memory freeze, taken branch, load-use bubble, fetch wait, run.
    always_comb begin
        state_nx   = ST_RUN;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        branch_go  = 1'b0;
        if (!rst) begin
            state_nx = ST_RUN;
        end else if (dmem_busy) begin
            state_nx = ST_MEMWAIT;
        end else if (ex_branch_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            branch_go  = 1'b1;
        end else if (lu_hit && (state != ST_LDSTALL)) begin
            // EX holds the bubble next cycle, so the same hit is masked there.
            state_nx   = ST_LDSTALL;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
        end else if (imem_busy) begin
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end
    end

    // Saturating statistics; reset cycles are never counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_go && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + FL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned FL_W      = 4;
    localparam int          STALL_MAX = 15;
    localparam int          FLUSH_MAX = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             dmem_busy;
    logic             imem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [FL_W-1:0]  flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: counts and whether the previous cycle inserted a load-use bubble.
    int m_stall = 0;
    int m_flush = 0;
    bit m_bubble_prev = 1'b0;
    bit m_valid = 1'b0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .FL_W(FL_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .imem_busy       (imem_busy),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_obs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    endfunction

    // One cycle: apply inputs after the falling edge, compare, then advance the model.
    task automatic cycle(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                         input logic br, input logic dm, input logic im);
        logic       hit;
        logic [6:0] exp;
        @(negedge clk);
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; dmem_busy = dm; imem_busy = im;
        #1;
        hit = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (!r)                        exp = 7'b00000_00;
        else if (dm)                   exp = 7'b00000_00;
        else if (br)                   exp = 7'b11111_11;
        else if (hit && !m_bubble_prev) exp = 7'b00111_01;
        else if (im)                   exp = 7'b01111_10;
        else                           exp = 7'b11111_00;
        check("ctrl", 32'(ctrl_obs()), 32'(exp));
        if (m_valid) begin
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        end
        if (!r) begin
            m_stall = 0;
            m_flush = 0;
            m_bubble_prev = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (!exp[6] && m_stall < STALL_MAX) m_stall++;
            if (!dm && br && m_flush < FLUSH_MAX) m_flush++;
            m_bubble_prev = !dm && !br && hit && !m_bubble_prev;
        end
    endtask

    task automatic quiet();
        cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();
        check("rst_outputs", 32'(ctrl_obs()), 32'd0);
        quiet();
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);

        // Load-use: one bubble, then masked in the following cycle.
        do_reset();
        cycle(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lu_stall", 32'({pc_en, ifid_en, idex_flush}), 32'(3'b001));
        cycle(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lu_masked", 32'(ctrl_obs()), 32'(7'b11111_00));
        quiet();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // x0 never creates a hazard.
        cycle(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("x0_no_stall", 32'(ctrl_obs()), 32'(7'b11111_00));

        // Branch beats load-use.
        do_reset();
        cycle(1'b1, 5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check("br_lu", 32'(ctrl_obs()), 32'(7'b11111_11));
        quiet();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory freeze holding a branch; branch fires on exit.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            check("mw_freeze", 32'(ctrl_obs()), 32'd0);
        end
        cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("mw_exit_br", 32'({ifid_flush, idex_flush, pc_en}), 32'(3'b111));
        quiet();
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw_flush_cnt", 32'(flush_cnt), 32'd1);
        check("mw_no_flush", 32'({ifid_flush, idex_flush}), 32'd0);

        // imem_busy and load-use together: load-use wins.
        cycle(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
        check("im_lu", 32'({ifid_en, ifid_flush, idex_flush}), 32'(3'b001));

        // Reset during MEMWAIT.
        cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("rst_in_mw", 32'(ctrl_obs()), 32'd0);
        quiet();
        check("rst_mw_en", 32'(ctrl_obs()), 32'(7'b11111_00));
        check("rst_mw_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);

        // Stall counter saturation.
        do_reset();
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        quiet();
        check("stall_sat", 32'(stall_cnt), 32'd15);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 39) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
